neuron_mac: RTL and testbench

Sequential, parametrised N-input perceptron neuron. It accepts a bias weight on `start_in`, then streams `N_INPUTS` (x, w) pairs through one sign-magnitude fixed-point multiply-accumulate datapath. It produces a saturated weighted sum and a step-activation bit. It replaces the fixed two-input combinational neuron wherever input count or area matters, and feeds layer controllers through a start/done handshake.

---
 rtl/neuron_pkg.sv | 54 +++++
 rtl/neuron_mac_product.sv | 57 +++++
 rtl/neuron_mac.sv | 168 ++++++++++++++++
 tb/tb_neuron_mac.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the sequential perceptron neuron: FSM states,
// width helpers, sign-magnitude <-> two's complement conversion, saturation limits.
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_FINAL
    } state_t;

    function automatic int word_width(int sign_bits, int q_m, int q_n);
        return sign_bits + q_m + q_n;
    endfunction

    // Headroom for the bias plus N full-scale products, so the sum never wraps.
    function automatic int acc_width(int w, int n_inputs);
        return w + 1 + $clog2(n_inputs + 1);
    endfunction

    function automatic int cnt_width(int n_inputs);
        return (n_inputs > 1) ? $clog2(n_inputs) : 1;
    endfunction

    function automatic logic [63:0] mag_limit(int mag_bits);
        return (64'd1 << mag_bits) - 64'd1;
    endfunction

    function automatic logic signed [63:0] sat_hi(int mag_bits);
        return signed'(mag_limit(mag_bits));
    endfunction

    function automatic logic signed [63:0] sat_lo(int mag_bits);
        return -signed'(mag_limit(mag_bits));
    endfunction

    // Sign bit sits directly above the magnitude field.
    function automatic logic signed [63:0] sm_to_tc(logic [63:0] sm, int mag_bits);
        logic signed [63:0] mag;
        mag = signed'(sm & mag_limit(mag_bits));
        return sm[mag_bits] ? -mag : mag;
    endfunction

    // A zero magnitude never carries a sign, so -0 cannot be produced.
    function automatic logic [63:0] tc_to_sm(logic signed [63:0] v, int mag_bits);
        logic [63:0] mag;
        logic        neg;
        neg = (v < 64'sd0);
        mag = neg ? -v : v;
        mag = mag & mag_limit(mag_bits);
        return (neg && (mag != 64'd0)) ? (mag | (64'd1 << mag_bits)) : mag;
    endfunction

endpackage

// File: rtl/neuron_mac_product.sv
// Sign-magnitude fixed-point multiplier: truncates toward zero, saturates the
// magnitude on overflow. Output register present when NEURON_MAC_PIPE_EN is defined.
module neuron_mac_product #(
    parameter int Q_M = 15,
    parameter int Q_N = 16
) (
`ifdef NEURON_MAC_PIPE_EN
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   p_valid,
`endif
    input  logic [Q_M+Q_N:0]       x,
    input  logic [Q_M+Q_N:0]       w,
    output logic [Q_M+Q_N:0]       p,
    output logic                   p_ovf
);
    localparam int MW = Q_M + Q_N;

    logic [MW-1:0]   mx;
    logic [MW-1:0]   mw;
    logic [2*MW-1:0] full;
    logic [2*MW-1:0] shr;
    logic [MW-1:0]   mag;
    logic            ovf_c;
    logic            sgn;
    logic [MW:0]     p_c;

    assign mx    = x[MW-1:0];
    assign mw    = w[MW-1:0];
    assign full  = {{MW{1'b0}}, mx} * {{MW{1'b0}}, mw};
    assign shr   = full >> Q_N;
    assign ovf_c = |shr[2*MW-1:MW];
    assign mag   = ovf_c ? '1 : shr[MW-1:0];
    assign sgn   = (x[MW] ^ w[MW]) & (|mag);
    assign p_c   = {sgn, mag};

`ifdef NEURON_MAC_PIPE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid <= 1'b0;
            p       <= '0;
            p_ovf   <= 1'b0;
        end else begin
            p_valid <= in_valid;
            if (in_valid) begin
                p     <= p_c;
                p_ovf <= ovf_c;
            end
        end
    end
`else
    assign p     = p_c;
    assign p_ovf = ovf_c;
`endif

endmodule

// File: rtl/neuron_mac.sv
// Sequential N-input perceptron: bias on start, then N (x,w) beats through one MAC,
// saturated sign-magnitude sum and step activation. NEURON_MAC_PIPE_EN adds a product stage.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int SIGN     = 1,
    parameter int Q_M      = 15,
    parameter int Q_N      = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_in,
    input  logic [word_width(SIGN,Q_M,Q_N)-1:0] wb_in,
    input  logic [word_width(SIGN,Q_M,Q_N)-1:0] x_in,
    input  logic [word_width(SIGN,Q_M,Q_N)-1:0] w_in,
    input  logic                                 x_valid_in,
    output logic                                 x_ready_out,
    output logic                                 busy_out,
    output logic                                 done_out,
    output logic [word_width(SIGN,Q_M,Q_N)-1:0] sum_out,
    output logic                                 out,
    output logic                                 overflow_out
);
    localparam int W  = word_width(SIGN, Q_M, Q_N);
    localparam int MW = Q_M + Q_N;
    localparam int AW = acc_width(W, N_INPUTS);
    localparam int CW = cnt_width(N_INPUTS);

    state_t               state_reg, state_next;
    logic signed [AW-1:0] acc_reg, acc_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic                 ovf_reg, ovf_next;
    logic [W-1:0]         sum_reg, sum_next;
    logic                 res_ovf_reg, res_ovf_next;
    logic                 out_reg, out_next;
    logic                 done_reg, done_next;

    logic                 beat_acc;
    logic                 add_en;
    logic [W-1:0]         p_sm;
    logic                 p_ovf;
    logic signed [AW-1:0] p_tc;
    logic signed [AW-1:0] bias_tc;
    logic signed [63:0]   acc_wide;
    logic signed [63:0]   acc_sat;
    logic                 clamp_hit;
    logic [W-1:0]         fin_sm;

    assign beat_acc = (state_reg == ST_ACCUM) && x_valid_in;

`ifdef NEURON_MAC_PIPE_EN
    localparam state_t LAST_BEAT_NEXT = ST_DRAIN;
    logic p_valid;

    neuron_mac_product #(.Q_M(Q_M), .Q_N(Q_N)) u_product (
        .clk      (clk),
        .rst      (rst),
        .in_valid (beat_acc),
        .p_valid  (p_valid),
        .x        (x_in),
        .w        (w_in),
        .p        (p_sm),
        .p_ovf    (p_ovf)
    );
    assign add_en = p_valid;
`else
    localparam state_t LAST_BEAT_NEXT = ST_FINAL;

    neuron_mac_product #(.Q_M(Q_M), .Q_N(Q_N)) u_product (
        .x     (x_in),
        .w     (w_in),
        .p     (p_sm),
        .p_ovf (p_ovf)
    );
    assign add_en = beat_acc;
`endif

    // The bias input is fixed at +1.0, so its product is the bias weight itself.
    assign p_tc    = AW'(sm_to_tc(64'(p_sm), MW));
    assign bias_tc = AW'(sm_to_tc(64'(wb_in), MW));

    always_comb begin
        acc_wide  = 64'(acc_reg);
        acc_sat   = acc_wide;
        clamp_hit = 1'b0;
        if (acc_wide > sat_hi(MW)) begin
            acc_sat   = sat_hi(MW);
            clamp_hit = 1'b1;
        end else if (acc_wide < sat_lo(MW)) begin
            acc_sat   = sat_lo(MW);
            clamp_hit = 1'b1;
        end
        fin_sm = W'(tc_to_sm(acc_sat, MW));
    end

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        ovf_next     = ovf_reg;
        sum_next     = sum_reg;
        res_ovf_next = res_ovf_reg;
        out_next     = out_reg;
        done_next    = 1'b0;

        if (add_en) begin
            acc_next = acc_reg + p_tc;
            if (p_ovf) ovf_next = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (start_in) begin
                    acc_next   = bias_tc;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat_acc) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == CW'(N_INPUTS - 1)) state_next = LAST_BEAT_NEXT;
                end
            end
            ST_DRAIN: state_next = ST_FINAL;
            ST_FINAL: begin
                sum_next     = fin_sm;
                res_ovf_next = ovf_reg | clamp_hit;
                out_next     = ~fin_sm[W-1] & (|fin_sm[MW-1:0]);
                done_next    = 1'b1;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            ovf_reg     <= 1'b0;
            sum_reg     <= '0;
            res_ovf_reg <= 1'b0;
            out_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            ovf_reg     <= ovf_next;
            sum_reg     <= sum_next;
            res_ovf_reg <= res_ovf_next;
            out_reg     <= out_next;
            done_reg    <= done_next;
        end
    end

    assign x_ready_out  = (state_reg == ST_ACCUM);
    assign busy_out     = (state_reg != ST_IDLE);
    assign done_out     = done_reg;
    assign sum_out      = sum_reg;
    assign out          = out_reg;
    assign overflow_out = res_ovf_reg;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac (Q15.16, two inputs): directed cases plus random
// evaluations checked by an arithmetic reference model; latency checked per evaluation.
module tb_neuron_mac;
    localparam int N = 2;
`ifdef NEURON_MAC_PIPE_EN
    localparam int PIPE_LAT = 1;
`else
    localparam int PIPE_LAT = 0;
`endif
    localparam longint MAXM = 64'sh7FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_in = 1'b0;
    logic [31:0] wb_in = '0;
    logic [31:0] x_in = '0;
    logic [31:0] w_in = '0;
    logic        x_valid_in = 1'b0;
    logic        x_ready_out, busy_out, done_out, out, overflow_out;
    logic [31:0] sum_out;

    neuron_mac #(.N_INPUTS(N), .SIGN(1), .Q_M(15), .Q_N(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_in     (start_in),
        .wb_in        (wb_in),
        .x_in         (x_in),
        .w_in         (w_in),
        .x_valid_in   (x_valid_in),
        .x_ready_out  (x_ready_out),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .sum_out      (sum_out),
        .out          (out),
        .overflow_out (overflow_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] sum;
        logic        ovf;
        logic        act;
        int          start_edge;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;
    int n_eval = 0;

    logic [31:0] bx [N];
    logic [31:0] bw [N];
    int          bg [N];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Reference: real-valued fixed-point arithmetic on the current beat arrays.
    function automatic void model(input logic [31:0] wb, output logic [31:0] s,
                                  output logic ov, output logic act);
        longint acc, mx, mw, p;
        acc = wb[31] ? -longint'(wb[30:0]) : longint'(wb[30:0]);
        ov  = 1'b0;
        for (int i = 0; i < N; i++) begin
            mx = longint'(bx[i][30:0]);
            mw = longint'(bw[i][30:0]);
            p  = (mx * mw) / 65536;
            if (p > MAXM) begin
                p  = MAXM;
                ov = 1'b1;
            end
            acc += (bx[i][31] ^ bw[i][31]) ? -p : p;
        end
        if (acc > MAXM) begin acc = MAXM; ov = 1'b1; end
        if (acc < -MAXM) begin acc = -MAXM; ov = 1'b1; end
        s   = (acc < 0) ? {1'b1, 31'(-acc)} : {1'b0, 31'(acc)};
        act = (acc > 0);
    endfunction

    task automatic run_eval(input logic [31:0] wb, input logic [31:0] es, input logic eo,
                            input logic ea, input bit junk, input bit mid_start, input bit b2b);
        exp_t e;
        int   t;
        int   stall;
        if (junk) begin
            x_valid_in = 1'b1;
            x_in = 32'hDEAD_BEEF;
            w_in = 32'h0005_0000;
            repeat (2) @(negedge clk);
        end
        stall = 0;
        for (int i = 0; i < N; i++) stall += bg[i];
        start_in     = 1'b1;
        wb_in        = wb;
        x_valid_in   = junk;
        e.sum        = es;
        e.ovf        = eo;
        e.act        = ea;
        e.start_edge = cyc + 1;
        e.lat        = N + 2 + PIPE_LAT + stall;
        sb.push_back(e);
        @(negedge clk);
        start_in = 1'b0;
        wb_in    = '0;
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < bg[i]; g++) begin
                x_valid_in = 1'b0;
                if (mid_start) begin
                    start_in = 1'b1;
                    wb_in    = 32'h7FFF_FFFF;
                end
                @(negedge clk);
            end
            start_in   = 1'b0;
            wb_in      = '0;
            x_valid_in = 1'b1;
            x_in       = bx[i];
            w_in       = bw[i];
            t = 0;
            while (!x_ready_out && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("beat_ready", 64'(x_ready_out), 64'd1);
            @(negedge clk);
        end
        x_valid_in = 1'b0;
        t = 0;
        while (!done_out && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("done_wait", 64'(done_out), 64'd1);
        if (!b2b) repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done_out) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
            end else begin
                e = sb.pop_front();
                check("sum_out", 64'(sum_out), 64'(e.sum));
                check("overflow_out", 64'(overflow_out), 64'(e.ovf));
                check("out", 64'(out), 64'(e.act));
                check("latency", 64'(cyc - e.start_edge + 1), 64'(e.lat));
                $display("eval %0d: sum=0x%08h out=%0b ovf=%0b lat=%0d", n_eval, sum_out,
                         out, overflow_out, cyc - e.start_edge + 1);
                n_eval++;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy_out), 64'd0);
        check({tag, "_ready"}, 64'(x_ready_out), 64'd0);
        check({tag, "_done"}, 64'(done_out), 64'd0);
        check({tag, "_sum"}, 64'(sum_out), 64'd0);
        check({tag, "_out"}, 64'(out), 64'd0);
        check({tag, "_ovf"}, 64'(overflow_out), 64'd0);
    endtask

    function automatic logic [31:0] rnd_sm();
        logic [31:0] m;
        case ($urandom_range(0, 3))
            0:       m = $urandom & 32'h0003_FFFF;
            1:       m = $urandom & 32'h00FF_FFFF;
            2:       m = $urandom & 32'h7FFF_FFFF;
            default: m = 32'h0;
        endcase
        m[31] = $urandom_range(0, 1) == 1;
        return m;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] es;
        logic        eo, ea, b2b;
        for (int i = 0; i < N; i++) bg[i] = 0;

        #1;
        check_idle_outputs("rst_async");
        repeat (3) @(negedge clk);
        check_idle_outputs("rst_held");
        rst = 1'b0;
        @(negedge clk);

        // AND gate, then back-to-back second evaluation
        bx[0] = 32'h0001_0000; bx[1] = 32'h0001_0000;
        bw[0] = 32'h0001_0000; bw[1] = 32'h0001_0000;
        run_eval(32'h8001_8000, 32'h0000_8000, 1'b0, 1'b1, 0, 0, 1);
        bx[1] = 32'h0000_0000;
        run_eval(32'h8001_8000, 32'h8000_8000, 1'b0, 1'b0, 0, 0, 0);

        // Zero result with a negative weight, junk beats offered while idle
        bx[0] = 32'h0; bx[1] = 32'h0;
        bw[0] = 32'h8001_0000; bw[1] = 32'h0001_0000;
        run_eval(32'h0, 32'h0000_0000, 1'b0, 1'b0, 1, 0, 0);

        // AND gate with 3-cycle valid gaps and ignored mid-evaluation start
        bx[0] = 32'h0001_0000; bx[1] = 32'h0001_0000;
        bw[0] = 32'h0001_0000; bw[1] = 32'h0001_0000;
        bg[0] = 3; bg[1] = 3;
        run_eval(32'h8001_8000, 32'h0000_8000, 1'b0, 1'b1, 0, 1, 0);
        bg[0] = 0; bg[1] = 0;

        // Product saturation
        bx[0] = 32'h7FFF_0000; bx[1] = 32'h0;
        bw[0] = 32'h0002_0000; bw[1] = 32'h0001_0000;
        run_eval(32'h0, 32'h7FFF_FFFF, 1'b1, 1'b1, 0, 0, 0);

        // Reset after the first accepted beat discards the evaluation
        start_in = 1'b1;
        wb_in    = 32'h0003_0000;
        @(negedge clk);
        start_in   = 1'b0;
        wb_in      = '0;
        x_valid_in = 1'b1;
        x_in       = 32'h0001_0000;
        w_in       = 32'h0001_0000;
        @(negedge clk);
        x_valid_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        bx[0] = 32'h0001_0000; bx[1] = 32'h0001_0000;
        bw[0] = 32'h0001_0000; bw[1] = 32'h0001_0000;
        run_eval(32'h8001_8000, 32'h0000_8000, 1'b0, 1'b1, 0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] wb;
            wb = rnd_sm();
            for (int i = 0; i < N; i++) begin
                bx[i] = rnd_sm();
                bw[i] = rnd_sm();
                bg[i] = $urandom_range(0, 2);
            end
            model(wb, es, eo, ea);
            b2b = $urandom_range(0, 1) == 1;
            run_eval(wb, es, eo, ea, 0, $urandom_range(0, 1) == 1, b2b);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
